// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding, counter sizing and parameter legality for rst_seq_ctrl
package rst_seq_pkg;
    typedef enum logic [1:0] {
        S_ASSERT    = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    function automatic int cnt_w(input int min_hold, input int lock_filt, input int step_dly);
        int m;
        m = min_hold > lock_filt ? min_hold : lock_filt;
        m = m > step_dly ? m : step_dly;
        return $clog2(m + 1);
    endfunction

    function automatic bit params_ok(input int sync_stages, input int n_rst, input int min_hold,
                                     input int lock_filt, input int step_dly);
        return sync_stages >= 2 && n_rst >= 1 && n_rst <= 16 &&
               min_hold >= 1 && lock_filt >= 1 && step_dly >= 1;
    endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: DEPTH-flop single-bit synchroniser with asynchronous active-low clear
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk_in,
    input  logic RSTn,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;

    // shift d through the chain; clearing is immediate so q drops with RSTn
    always_ff @(posedge clk_in or negedge RSTn)
        if (!RSTn) sr <= '0;
        else sr <= {sr[DEPTH-2:0], d};

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: synchronises board reset and PLL lock, then releases N_RST reset domains in order
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N_RST       = 4,
    parameter int MIN_HOLD    = 4,
    parameter int LOCK_FILT   = 16,
    parameter int STEP_DLY    = 8
) (
    input  logic             clk_in,
    input  logic             RSTn,
    input  logic             i_locked,
    input  logic             i_soft_rst,
    output logic [N_RST-1:0] o_rst_n,
    output logic             o_ready,
    output logic [1:0]       o_state
);
    localparam int CW = cnt_w(MIN_HOLD, LOCK_FILT, STEP_DLY);
    localparam logic [CW-1:0] HOLD_END = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] FILT_END = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] STEP_END = CW'(STEP_DLY - 1);

    if (!params_ok(SYNC_STAGES, N_RST, MIN_HOLD, LOCK_FILT, STEP_DLY)) begin : g_bad_params
        $error("rst_seq_ctrl: illegal parameter set");
    end

    state_t           state, nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N_RST-1:0] rst_q, rst_nxt;
    logic             rst_sync, lock_sync, abort;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_rst_sync (
        .clk_in(clk_in), .RSTn(RSTn), .d(1'b1), .q(rst_sync)
    );

    sync_ff #(.DEPTH(SYNC_STAGES)) u_lock_sync (
        .clk_in(clk_in), .RSTn(RSTn), .d(i_locked), .q(lock_sync)
    );

    assign abort = !lock_sync || i_soft_rst;

    // next state, shared phase counter and thermometer release pattern
    always_comb begin
        nxt     = state;
        cnt_nxt = '0;
        rst_nxt = rst_q;
        case (state)
            S_ASSERT: begin
                rst_nxt = '0;
                nxt     = cnt == HOLD_END ? S_WAIT_LOCK : S_ASSERT;
                cnt_nxt = cnt == HOLD_END ? '0 : cnt + 1'b1;
            end
            S_WAIT_LOCK: begin
                nxt     = i_soft_rst ? S_ASSERT : (lock_sync && cnt == FILT_END) ? S_RELEASE : S_WAIT_LOCK;
                cnt_nxt = (i_soft_rst || !lock_sync || cnt == FILT_END) ? '0 : cnt + 1'b1;
            end
            S_RELEASE: begin
                if (abort) begin
                    nxt     = S_ASSERT;
                    rst_nxt = '0;
                end else if (cnt == STEP_END) begin
                    rst_nxt = (rst_q << 1) | N_RST'(1);
                    nxt     = &rst_nxt ? S_RUN : S_RELEASE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                nxt     = abort ? S_ASSERT : S_RUN;
                rst_nxt = abort ? '0 : rst_q;
            end
        endcase
    end

    // registers held in S_ASSERT until the reset release has crossed the synchroniser
    always_ff @(posedge clk_in or negedge RSTn)
        if (!RSTn) begin
            state   <= S_ASSERT;
            cnt     <= '0;
            rst_q   <= '0;
            o_ready <= 1'b0;
        end else if (!rst_sync) begin
            state   <= S_ASSERT;
            cnt     <= '0;
            rst_q   <= '0;
            o_ready <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            rst_q   <= rst_nxt;
            o_ready <= state == S_RUN && nxt == S_RUN;
        end

    assign o_rst_n = rst_q;
    assign o_state = state;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: randomised lock/soft-reset stimulus against an edge-timeline model of the sequencer
module tb_rst_seq_ctrl;
    localparam int S = 2, N = 4, MH = 4, LF = 16, SD = 8;

    logic clk_in = 0, RSTn = 0, i_locked = 0, i_soft_rst = 0;
    logic [N-1:0] o_rst_n;
    logic         o_ready;
    logic [1:0]   o_state;
    logic [0:0]   o_rst_n2;
    logic         o_ready2;
    logic [1:0]   o_state2;

    int tests = 0, fails = 0;
    int cyc = 0, r_edge = S, q_edge = 0, run = 0;
    bit lk [0:8191];
    bit sf [0:8191];

    always #5 clk_in = ~clk_in;

    rst_seq_ctrl dut (
        .clk_in(clk_in), .RSTn(RSTn), .i_locked(i_locked), .i_soft_rst(i_soft_rst),
        .o_rst_n(o_rst_n), .o_ready(o_ready), .o_state(o_state)
    );

    rst_seq_ctrl #(.SYNC_STAGES(2), .N_RST(1), .MIN_HOLD(1), .LOCK_FILT(1), .STEP_DLY(1)) dut2 (
        .clk_in(clk_in), .RSTn(RSTn), .i_locked(i_locked), .i_soft_rst(i_soft_rst),
        .o_rst_n(o_rst_n2), .o_ready(o_ready2), .o_state(o_state2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, cyc);
        end
    endtask

    // released-domain count: one per STEP_DLY edges after the lock filter completes
    function automatic int n_rel();
        int n;
        if (q_edge == 0) return 0;
        n = (cyc - q_edge) / SD;
        return n > N ? N : n;
    endfunction

    function automatic int exp_state();
        if (q_edge == 0) return cyc >= r_edge + MH ? 1 : 0;
        return n_rel() == N ? 3 : 2;
    endfunction

    function automatic bit exp_ready();
        return q_edge != 0 && cyc > q_edge + N * SD;
    endfunction

    // timeline model: lock seen by the sequencer at edge e is i_locked sampled at edge e-S
    task automatic model_step();
        bit ls;
        ls = cyc > S ? lk[cyc-S] : 1'b0;
        if (q_edge != 0) begin
            if (!ls || sf[cyc]) begin r_edge = cyc; q_edge = 0; run = 0; end
        end else if (cyc > r_edge + MH) begin
            if (sf[cyc]) begin r_edge = cyc; run = 0; end
            else if (ls) begin run++; if (run == LF) q_edge = cyc; end
            else run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        cyc++;
        lk[cyc] = i_locked;
        sf[cyc] = i_soft_rst;
        model_step();
        #1;
        check("rst_n", o_rst_n, (1 << n_rel()) - 1);
        check("ready", o_ready, exp_ready());
        check("state", o_state, exp_state());
    endtask

    task automatic wait_rel(input int k);
        int b = 0;
        while (!(q_edge != 0 && n_rel() >= k) && b < 600) begin tick(); b++; end
        check("wait_rel_timeout", b < 600, 1);
    endtask

    task automatic wait_ready();
        int b = 0;
        while (!exp_ready() && b < 600) begin tick(); b++; end
        check("wait_ready_timeout", b < 600, 1);
    endtask

    task automatic soft_pulse();
        i_soft_rst = 1;
        tick();
        i_soft_rst = 0;
    endtask

    initial begin
        int a, b;
        i_locked = 1;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_rst_n", o_rst_n, 0);
        check("reset_ready", o_ready, 0);
        check("reset_state", o_state, 0);
        check("reset_rst_n2", o_rst_n2, 0);
        RSTn = 1;

        // minimal-parameter instance: release at edge SYNC_STAGES+3, ready one edge later
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i >= 4) check("sweep_rst_n", o_rst_n2, i >= 5);
            if (i >= 5) check("sweep_ready", o_ready2, i >= 6);
            if (i == 5) check("sweep_state", o_state2, 3);
        end

        b = 0;
        while (o_ready !== 1'b1 && b < 200) begin tick(); b++; end
        check("ready_edge", cyc, 55);
        check("run_state", o_state, 3);

        // soft reset after bit 1 released: 0011 -> 0000, then MIN_HOLD edges in S_ASSERT
        soft_pulse();
        wait_rel(2);
        check("pre_soft", o_rst_n, 4'b0011);
        a = cyc;
        soft_pulse();
        check("soft_clr", o_rst_n, 0);
        b = 0;
        while (o_state !== 2'd1 && b < 50) begin tick(); b++; end
        check("hold_len", cyc - a - 1, MH);
        wait_ready();

        // lock loss in S_RUN propagates after SYNC_STAGES edges
        tick();
        i_locked = 0;
        a = cyc + 1;
        b = 0;
        while (o_rst_n !== '0 && b < 20) begin tick(); b++; end
        check("lock_loss_edge", cyc, a + S);
        check("lock_loss_ready", o_ready, 0);
        i_locked = 1;
        wait_ready();

        // lock glitches during S_WAIT_LOCK never let the filter complete
        soft_pulse();
        for (int g = 0; g < 6; g++) begin
            repeat ($urandom_range(3, 14)) tick();
            i_locked = 0;
            tick();
            i_locked = 1;
        end
        check("glitch_hold", o_rst_n, 0);
        wait_ready();

        // randomised aborts: soft in release, lock loss (optionally with soft), soft in wait
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    soft_pulse();
                    wait_rel($urandom_range(1, N - 1));
                    repeat ($urandom_range(0, SD - 1)) tick();
                    soft_pulse();
                end
                1: begin
                    i_locked = 0;
                    i_soft_rst = 1'($urandom_range(0, 1));
                    tick();
                    i_soft_rst = 0;
                    repeat ($urandom_range(0, 4)) tick();
                    i_locked = 1;
                end
                default: begin
                    soft_pulse();
                    repeat (MH + $urandom_range(1, 12)) tick();
                    soft_pulse();
                end
            endcase
            wait_ready();
        end

        // asynchronous reset during S_RELEASE clears outputs without a clock edge
        soft_pulse();
        wait_rel(2);
        #3 RSTn = 0;
        #1;
        check("async_rst_n", o_rst_n, 0);
        check("async_state", o_state, 0);
        check("async_ready", o_ready, 0);
        #1 RSTn = 1;
        cyc = 0; r_edge = S; q_edge = 0; run = 0;
        b = 0;
        while (o_ready !== 1'b1 && b < 200) begin tick(); b++; end
        check("ready_edge_again", cyc, 55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised reset sequencer that replaces the fixed two-flop reset synchroniser in front of the PLL-derived system clock. It synchronises the async board reset and the PLL lock flag, filters lock, then releases N_RST reset domains one after another with a fixed spacing. Loss of lock or a soft-reset request re-asserts every output and reruns the sequence. It sits between the PLL wrapper and all downstream logic in the clk_in domain.

Parameters:
SYNC_STAGES, 2, flop depth of reset and lock synchronisers (>=2).
N_RST, 4, number of sequenced active-low reset outputs (1..16).
MIN_HOLD, 4, cycles all outputs are held asserted in S_ASSERT (>=1).
LOCK_FILT, 16, consecutive synced-lock-high cycles required before release (>=1).
STEP_DLY, 8, cycles between successive output releases (>=1).

Ports:
clk_in  input  1  system clock (PLL output domain); all logic is on its rising edge.
RSTn  input  1  asynchronous active-low reset; assertion takes effect asynchronously, deassertion is synchronised internally.
i_locked  input  1  PLL lock, asynchronous to clk_in.
i_soft_rst  input  1  synchronous request, level-sensitive, sampled every cycle.
o_rst_n  output  N_RST  sequenced active-low resets; bit 0 is released first.
o_ready  output  1  high once all outputs are released and the block is in S_RUN.
o_state  output  2  current FSM state, for debug.

Behaviour:
- RSTn low: asynchronously clear the synchroniser flops, FSM, and counters. Then o_rst_n = 0, o_ready = 0, o_state = S_ASSERT. This holds until RSTn is high and has propagated through SYNC_STAGES flops (rst_sync).
- i_locked passes through a SYNC_STAGES synchroniser (lock_sync), reset to 0 by RSTn.
- FSM states (2-bit): S_ASSERT = 0, S_WAIT_LOCK = 1, S_RELEASE = 2, S_RUN = 3.
- S_ASSERT:
  - o_rst_n all 0; hold counter counts MIN_HOLD cycles, then S_WAIT_LOCK.
  - lock_sync and i_soft_rst are ignored here.
- S_WAIT_LOCK:
  - filter counter increments while lock_sync = 1 and clears to 0 on any cycle with lock_sync = 0.
  - Reaching LOCK_FILT consecutive cycles enters S_RELEASE.
  - i_soft_rst = 1 returns to S_ASSERT and the hold count restarts.
- S_RELEASE:
  - step counter counts STEP_DLY cycles per step; at the end of step k (k = 0..N_RST-1), o_rst_n[k] is set to 1.
  - Released bits stay high; the outputs are thermometer-coded.
  - After bit N_RST-1 is released, enter S_RUN.
- S_RUN: o_ready = 1, registered, one cycle after the last bit is released.
- Return to S_ASSERT on the next edge when lock_sync = 0 or i_soft_rst = 1 in S_RELEASE or S_RUN:
  - all o_rst_n bits clear and o_ready clears on that edge.
  - All counters clear.
  - If lock loss and soft reset occur together, there is one transition only.
- Normative timing. Edge 1 is the first clk_in rising edge with RSTn high. With i_locked held high:
  - T0 = SYNC_STAGES + MIN_HOLD + LOCK_FILT.
  - o_rst_n[k] rises at edge T0 + (k+1)*STEP_DLY.
  - o_ready rises one edge after o_rst_n[N_RST-1].
- Counter widths are $clog2(max(MIN_HOLD, LOCK_FILT, STEP_DLY)+1); no counter wraps, because each saturates at its terminal value and transitions.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- RSTn asserted mid-sequence aborts immediately (async) and restarts from S_ASSERT on deassertion.

Decomposition:
- Package rst_seq_pkg:
  - state encoding localparams (S_ASSERT..S_RUN);
  - counter-width function;
  - parameter legality checks (SYNC_STAGES>=2, N_RST<=16).
- One sub-module, sync_ff: a parametrised DEPTH single-bit synchroniser with async active-low clear. It is instantiated twice, once for RSTn (D = 1) and once for i_locked.

Test Plan:
- Defaults, i_locked = 1 before reset release, RSTn rises -> o_rst_n[0] rises at edge 30, [1] at 38, [2] at 46, [3] at 54, o_ready = 1 at edge 55, o_state = 3.
- i_locked toggles low for 1 cycle every 10 cycles during S_WAIT_LOCK -> filter never completes, o_rst_n stays 4'b0000; once held high, release starts after 16 clean synced cycles.
- In S_RUN, drop i_locked -> SYNC_STAGES edges later, o_rst_n = 0 and o_ready = 0 on the same edge. Re-raise -> full resequence with identical step spacing of 8.
- One-cycle i_soft_rst pulse in S_RELEASE after bit 1 is released -> o_rst_n goes 4'b0011 to 4'b0000 next edge, with MIN_HOLD = 4 cycles in S_ASSERT before waiting for lock.
- RSTn pulsed low asynchronously mid-cycle during S_RELEASE -> o_rst_n = 0 with no clock edge, and o_state = 0.
- Parameter sweep N_RST = 1, STEP_DLY = 1, LOCK_FILT = 1, MIN_HOLD = 1 -> o_rst_n[0] at edge SYNC_STAGES + 3, and o_ready one edge later.
